dmem_arbiter: RTL

Two-requester arbiter that shares the single data-memory port between the CPU load/store stage (requester 0) and the NN weight/output engine (requester 1). It runs round-robin arbitration with bounded burst ownership. It drives the memory's write enable, address and write data, and registers read data back to the owning requester. It sits directly in front of the data memory and is the only agent allowed to drive that memory's write port.

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-memory port between the CPU load/store stage
// (requester 0) and the NN weight/output engine (requester 1). Arbitration is
// round-robin with bounded burst ownership: an owner keeps the port until it
// marks the last beat, reaches MAX_BURST accepted beats, or stops requesting.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req*/we*/last*         per-requester beat request, write flag, last-beat flag
//   addr*/wdata*           per-requester beat address and write data
//   gnt*                   beat accepted this cycle (combinational)
//   rvalid*/rdata*         registered read response, one cycle after the read gnt
//   mem_we/mem_addr/mem_wdata  memory write port drive
//   mem_rdata              combinational read data from memory at mem_addr
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  last0,
  input  logic                  last1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic            own0, own1;
  logic            own_req, own_last, other_req;
  logic            acc, rel;
  logic [CW-1:0]   bcnt_inc;

  // Grants qualified by rst_n so nothing is accepted (or written) in a reset cycle.
  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign gnt0 = own0 && req0 && rst_n;
  assign gnt1 = own1 && req1 && rst_n;

  assign mem_addr  = own1 ? addr1 : addr0;
  assign mem_wdata = own1 ? wdata1 : wdata0;
  assign mem_we    = (gnt0 && we0) || (gnt1 && we1);

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

  assign own_req   = own1 ? req1  : req0;
  assign own_last  = own1 ? last1 : last0;
  assign other_req = own1 ? req0  : req1;
  assign acc       = gnt0 || gnt1;
  assign bcnt_inc  = bcnt_q + CW'(1);

  // last and the burst cap may coincide in one beat; both feed a single release.
  assign rel = (acc && (own_last || (bcnt_inc == CW'(MAX_BURST)))) || !own_req;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    bcnt_d    = bcnt_q;
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    rdata0_d  = (gnt0 && !we0) ? mem_rdata : rdata0_q;
    rdata1_d  = (gnt1 && !we1) ? mem_rdata : rdata1_q;

    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (req0 && req1) state_d = rr_q ? OWN1 : OWN0;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (acc) bcnt_d = bcnt_inc;
        if (rel) begin
          // rr points at the requester that did not just own the port.
          rr_d   = own0;
          bcnt_d = '0;
          if (other_req)           state_d = own0 ? OWN1 : OWN0;
          else if (own_req && acc) state_d = state_q;
          else                     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      bcnt_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      bcnt_q    <= bcnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

endmodule
